fir_tdm_scheduler: RTL

- Parametrised N-channel time-division scheduler that shares one Avalon-ST FIR interpolator across all audio channels.
- Input side: takes a parallel frame of NCH samples from the I2S receiver and issues one sample per cycle to the FIR, framed with sop/eop.
- Output side: collects the FIR output beats back into per-channel registers and presents a parallel frame to the I2S transmitter.
- Adds a runtime FIR bypass mode, overrun detection and source-framing error detection.

---
 rtl/fir_tdm_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fir_tdm_scheduler.sv
// Time-division scheduler that shares one Avalon-ST FIR across NCH audio channels.
// Serialises input frames into sop/eop packets, regathers FIR beats into frames, and offers a bypass path.
module fir_tdm_scheduler #(
  parameter int NCH   = 2,
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic                 AMCLK_i,
  input  logic                 ARST,
  input  logic [NCH*IN_W-1:0]  in_data_i,
  input  logic                 in_valid_i,
  input  logic                 bypass_i,
  input  logic                 clr_err_i,
  output logic [IN_W-1:0]      fir_sink_data_o,
  output logic                 fir_sink_valid_o,
  output logic                 fir_sink_sop_o,
  output logic                 fir_sink_eop_o,
  input  logic [OUT_W-1:0]     fir_source_data_i,
  input  logic                 fir_source_valid_i,
  input  logic                 fir_source_sop_i,
  input  logic                 fir_source_eop_i,
  output logic [NCH*OUT_W-1:0] out_data_o,
  output logic                 out_valid_o,
  output logic                 overrun_o,
  output logic                 chan_err_o
);

  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SH = OUT_W - IN_W;
  localparam logic [KW-1:0] LAST = KW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [KW-1:0]                e_q, e_d;
  logic [NCH-1:0][IN_W-1:0]     in_frame;
  logic [NCH-1:0][IN_W-1:0]     frame_q;
  logic [NCH-1:0][OUT_W-1:0]    shadow_q;
  logic [NCH-1:0][OUT_W-1:0]    byp_frame;
  logic [NCH-1:0][OUT_W-1:0]    fir_frame;
  logic [KW-1:0]                src_idx;
  logic                         accept;
  logic                         overrun_set;
  logic                         chan_set;
  logic                         shadow_we;
  logic                         fir_commit;

  assign in_frame    = in_data_i;
  assign overrun_set = in_valid_i && (state_q != IDLE);

  // Issue FSM: next state, channel counter and the combinational sink beat.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d          = state_q;
    k_d              = k_q;
    accept           = 1'b0;
    fir_sink_valid_o = 1'b0;
    fir_sink_data_o  = '0;
    fir_sink_sop_o   = 1'b0;
    fir_sink_eop_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          accept = 1'b1;
          if (!bypass_i) begin
            state_d = ISSUE;
            k_d     = '0;
          end
        end
      end
      ISSUE: begin
        fir_sink_valid_o = 1'b1;
        fir_sink_data_o  = frame_q[k_q];
        fir_sink_sop_o   = (k_q == '0);
        fir_sink_eop_o   = (k_q == LAST);
        if (k_q == LAST) state_d = GAP;
        else             k_d     = k_q + 1'b1;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bypass path: sign-extend, then align to the FIR output's MSBs.
  always_comb begin
    for (int c = 0; c < NCH; c++)
      byp_frame[c] = OUT_W'(signed'(in_frame[c])) << SH;
  end

  // Source collector: a sop beat always restarts the frame at index 0.
  assign src_idx = fir_source_sop_i ? '0 : e_q;

  always_comb begin
    fir_frame          = shadow_q;
    fir_frame[src_idx] = fir_source_data_i;
  end

  always_comb begin
    e_d        = e_q;
    shadow_we  = 1'b0;
    fir_commit = 1'b0;
    chan_set   = 1'b0;
    if (fir_source_valid_i) begin
      if (fir_source_sop_i && (e_q != '0)) chan_set = 1'b1;
      if (!fir_source_sop_i && (e_q == '0)) begin
        chan_set = 1'b1;
      end else begin
        shadow_we = 1'b1;
        if (fir_source_eop_i) begin
          e_d = '0;
          if (src_idx == LAST) fir_commit = 1'b1;
          else                 chan_set   = 1'b1;
        end else if (src_idx == LAST) begin
          e_d      = '0;
          chan_set = 1'b1;
        end else begin
          e_d = src_idx + 1'b1;
        end
      end
    end
  end

  // The sink data is gated by valid, so the frame latch needs no reset.
  always_ff @(posedge AMCLK_i) begin
    if (accept) frame_q <= in_frame;
  end

  always_ff @(posedge AMCLK_i) begin
    if (ARST) begin
      state_q     <= IDLE;
      k_q         <= '0;
      e_q         <= '0;
      // NOTE: the shadow buffer is small and must come up clean, so it is reset like any register.
      shadow_q    <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
      chan_err_o  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q     <= state_d;
      k_q         <= k_d;
      e_q         <= e_d;
      if (shadow_we) shadow_q[src_idx] <= fir_source_data_i;
      out_valid_o <= 1'b0;
      if (accept && bypass_i) begin
        out_data_o  <= byp_frame;
        out_valid_o <= 1'b1;
      end else if (fir_commit) begin
        out_data_o  <= fir_frame;
        out_valid_o <= 1'b1;
      end
      if (overrun_set)    overrun_o <= 1'b1;
      else if (clr_err_i) overrun_o <= 1'b0;
      if (chan_set)       chan_err_o <= 1'b1;
      else if (clr_err_i) chan_err_o <= 1'b0;
    end
  end

endmodule
